instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
Fetch stage that sits directly upstream of the instruction memory and feeds the decode stage.
- Owns the program counter and drives the word-indexed memory address.
- Captures the returned 32-bit instruction into an IF/ID register with a valid/ready handshake toward decode.
- Accepts branch/jump redirects from execute.
- Enters a sticky fault state on a misaligned redirect target or an out-of-range fetch.

Parameters:
XLEN, 64, program counter and address width
RESET_PC, 64'd0, byte address loaded into the PC on reset
IMEM_WORDS, 32, number of valid instruction words; a word index >= IMEM_WORDS is out of range

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous, active-low reset
imem_addr  out  XLEN  word index into instruction memory (pc >> 2), combinational
imem_data  in  32  instruction word returned combinationally for imem_addr
redirect_valid  in  1  execute requests PC redirect this cycle
redirect_pc  in  XLEN  byte-address redirect target
id_ready  in  1  decode can accept the IF/ID entry
id_valid  out  1  IF/ID entry valid
id_instr  out  32  fetched instruction
id_pc  out  XLEN  byte address of id_instr
id_pc_plus4  out  XLEN  id_pc + 4 (link value for jal/jalr)
fault  out  1  sticky fault flag
fault_pc  out  XLEN  address that caused the fault
fetch_count  out  32  number of instructions delivered into IF/ID, saturating

Behaviour:
- Reset (asynchronous, rst_n=0) sets:
  - pc=RESET_PC, state=BOOT, id_valid=0, id_instr=32'h00000013 (NOP).
  - id_pc=0, id_pc_plus4=0, fault=0, fault_pc=0, fetch_count=0.
  - Reset taking effect mid-operation discards any IF/ID entry.
- imem_addr = pc >> 2 at all times, including BOOT and FAULT.
- States:
  - BOOT: one cycle after reset release; no fetch. Next state is RUN.
  - RUN: normal fetch.
  - FAULT: terminal until reset.
- Handshake: accept = !id_valid || id_ready. Decode consumes an entry on id_valid && id_ready.
- Priority in RUN, highest first:
  1. redirect_valid=1:
     - Set pc <= redirect_pc and id_valid <= 0, flushing the wrong-path entry regardless of id_ready. fetch_count does not change.
     - If redirect_pc[1:0] != 0: go to FAULT, fault <= 1, fault_pc <= redirect_pc, and pc is not updated.
  2. accept && (pc>>2) >= IMEM_WORDS:
     - Go to FAULT, fault <= 1, fault_pc <= pc, id_valid <= 0.
  3. accept:
     - Load id_instr <= imem_data, id_pc <= pc, id_pc_plus4 <= pc+4, id_valid <= 1.
     - pc <= pc+4; fetch_count++ (saturates at 32'hFFFFFFFF).
  4. Otherwise (stall): hold every register.
- Redirect in BOOT:
  - pc <= redirect_pc, then go to RUN.
  - Misaligned target goes to FAULT exactly as in RUN.
- FAULT:
  - No fetches; redirects are ignored.
  - pc is held.
  - An id_valid=1 entry held at fault entry is not possible, because fault entry clears it.
- Latency: the instruction at pc appears on id_instr one cycle after the accept cycle. Throughput is 1 per cycle while id_ready=1.
- Arithmetic: pc+4 wraps modulo 2^XLEN. No other width extension is performed.
- A simultaneous redirect and decode consume drops the consumed entry normally and flushes nothing else; the new target is fetched the following cycle.

Decomposition:
- Shared package riscv_pkg holds:
  - XLEN and INSTR_W=32.
  - NOP_INSTR=32'h00000013.
  - fetch_state_t enum {BOOT, RUN, FAULT}.
- Natural sub-module: if_id_register.
  - Contents: id_valid, id_instr, id_pc, id_pc_plus4.
  - Inputs: load, flush, hold.
  - Resets to NOP and valid=0.
- The PC, FSM and counter stay in instruction_fetch.

Test Plan:
- Reset/boot:
  - Stimulus: hold rst_n=0, then release with id_ready=1. The imem model has word0=32'h01002083 and word1=32'h01502103.
  - Required response: cycle 0 after release gives id_valid=0 (BOOT). Cycle 2 gives id_instr=01002083 and id_pc=0. Cycle 3 gives id_instr=01502103, id_pc=4, id_pc_plus4=8, fetch_count=2.
- Stall:
  - Stimulus: drop id_ready for 3 cycles while id_valid=1 with id_pc=8.
  - Required response: id_pc stays 8, pc stays 12, and imem_addr=3 is stable. Raising id_ready resumes with id_pc=12 next cycle and no duplicate or lost instruction.
- Redirect:
  - Stimulus: with pc=28, assert redirect_valid with redirect_pc=8 and id_ready=0.
  - Required response: next cycle id_valid=0, imem_addr=2. The following cycle id_pc=8. fetch_count is unchanged by the flush.
- Misaligned redirect:
  - Stimulus: redirect_pc=64'h6.
  - Required response: fault=1 and fault_pc=6 next cycle. No further id_valid. A later redirect_valid to 0 is ignored. Asserting rst_n=0 clears fault asynchronously.
- Out-of-range:
  - Stimulus: straight-line run from 0 with IMEM_WORDS=32.
  - Required response: the last delivered id_pc is 124, then fault=1 with fault_pc=128. fetch_count=32.
- Reset mid-stream:
  - Stimulus: assert rst_n=0 between clock edges while id_valid=1.
  - Required response: id_valid=0, pc=RESET_PC and id_instr=NOP immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared fetch-stage types and constants.
//   XLEN      : default PC / address width
//   INSTR_W   : instruction word width
//   CNT_W     : fetch counter width
//   NOP_INSTR : addi x0,x0,0, the value an empty IF/ID entry carries
//   fetch_state_t : BOOT / RUN / FAULT
//   sat_inc() : saturating increment for the fetch counter
package riscv_pkg;

  localparam int unsigned XLEN    = 64;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned CNT_W   = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register: holds one fetched instruction for decode.
// Ports:
//   clk, rst_n      : clock, async active-low reset (entry becomes invalid NOP)
//   load_i          : capture instr_i/pc_i/pc_plus4_i and mark valid
//   flush_i         : invalidate the entry (wins over load_i)
//   hold_i          : stall; suppresses a load and keeps the entry as is
//   instr_i, pc_i, pc_plus4_i : payload to capture
//   valid_o, instr_o, pc_o, pc_plus4_o : registered entry
module if_id_register
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = riscv_pkg::XLEN
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic               flush_i,
  input  logic               hold_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [XLEN-1:0]    pc_i,
  input  logic [XLEN-1:0]    pc_plus4_i,
  output logic               valid_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [XLEN-1:0]    pc_o,
  output logic [XLEN-1:0]    pc_plus4_o
);

  logic               valid_q;
  logic [INSTR_W-1:0] instr_q;
  logic [XLEN-1:0]    pc_q;
  logic [XLEN-1:0]    pc_plus4_q;

  // Flush only drops the valid bit; the stale payload is never observed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      instr_q    <= NOP_INSTR;
      pc_q       <= '0;
      pc_plus4_q <= '0;
    end else if (flush_i) begin
      valid_q    <= 1'b0;
    end else if (load_i && !hold_i) begin
      valid_q    <= 1'b1;
      instr_q    <= instr_i;
      pc_q       <= pc_i;
      pc_plus4_q <= pc_plus4_i;
    end
  end

  assign valid_o    = valid_q;
  assign instr_o    = instr_q;
  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_plus4_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, reads the instruction memory and fills IF/ID.
// Ports:
//   clk, rst_n      : clock, async active-low reset
//   imem_addr       : word index (pc >> 2) into instruction memory
//   imem_data       : instruction word for imem_addr (combinational return)
//   redirect_valid, redirect_pc : branch/jump target from execute
//   id_ready        : decode accepts the IF/ID entry
//   id_valid, id_instr, id_pc, id_pc_plus4 : IF/ID entry toward decode
//   fault, fault_pc : sticky fault flag and the offending address
//   fetch_count     : instructions delivered into IF/ID, saturating
module instruction_fetch
  import riscv_pkg::*;
#(
  parameter int unsigned     XLEN       = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int unsigned     IMEM_WORDS = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [XLEN-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  input  logic               id_ready,
  output logic               id_valid,
  output logic [INSTR_W-1:0] id_instr,
  output logic [XLEN-1:0]    id_pc,
  output logic [XLEN-1:0]    id_pc_plus4,
  output logic               fault,
  output logic [XLEN-1:0]    fault_pc,
  output logic [CNT_W-1:0]   fetch_count
);

  fetch_state_t      state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic              fault_q, fault_d;
  logic [XLEN-1:0]   fault_pc_q, fault_pc_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              accept;
  logic              out_of_range;
  logic              misaligned;
  logic [XLEN-1:0]   word_idx;
  logic [XLEN-1:0]   pc_plus4;
  logic              ifid_load;
  logic              ifid_flush;

  assign word_idx     = pc_q >> 2;
  assign imem_addr    = word_idx;
  assign pc_plus4     = pc_q + XLEN'(4);
  assign accept       = !id_valid || id_ready;
  assign out_of_range = word_idx >= XLEN'(IMEM_WORDS);
  assign misaligned   = redirect_pc[1:0] != 2'b00;

  // State, PC, fault and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      fault_q    <= 1'b0;
      fault_pc_q <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fault_q    <= fault_d;
      fault_pc_q <= fault_pc_d;
      count_q    <= count_d;
    end
  end

  // Next-state: redirect beats range fault beats fetch beats stall.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fault_d    = fault_q;
    fault_pc_d = fault_pc_q;
    count_d    = count_q;
    ifid_load  = 1'b0;
    ifid_flush = 1'b0;

    unique case (state_q)
      BOOT: begin
        state_d = RUN;
        if (redirect_valid) begin
          ifid_flush = 1'b1;
          if (misaligned) begin
            state_d    = FAULT;
            fault_d    = 1'b1;
            fault_pc_d = redirect_pc;
          end else begin
            pc_d = redirect_pc;
          end
        end
      end

      RUN: begin
        if (redirect_valid) begin
          // Wrong-path entry is dropped whether or not decode takes it.
          ifid_flush = 1'b1;
          if (misaligned) begin
            state_d    = FAULT;
            fault_d    = 1'b1;
            fault_pc_d = redirect_pc;
          end else begin
            pc_d = redirect_pc;
          end
        end else if (accept && out_of_range) begin
          ifid_flush = 1'b1;
          state_d    = FAULT;
          fault_d    = 1'b1;
          fault_pc_d = pc_q;
        end else if (accept) begin
          ifid_load = 1'b1;
          pc_d      = pc_plus4;
          count_d   = sat_inc(count_q);
        end
      end

      FAULT: begin
        // Terminal until reset; redirects and fetches are ignored.
      end

      default: begin
        state_d = FAULT;
      end
    endcase
  end

  if_id_register #(
    .XLEN (XLEN)
  ) u_if_id (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (ifid_load),
    .flush_i    (ifid_flush),
    .hold_i     (!accept),
    .instr_i    (imem_data),
    .pc_i       (pc_q),
    .pc_plus4_i (pc_plus4),
    .valid_o    (id_valid),
    .instr_o    (id_instr),
    .pc_o       (id_pc),
    .pc_plus4_o (id_pc_plus4)
  );

  assign fault       = fault_q;
  assign fault_pc    = fault_pc_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

  logic        clk;
  logic        rst_n;
  logic [63:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [63:0] id_pc;
  logic [63:0] id_pc_plus4;
  logic        fault;
  logic [63:0] fault_pc;
  logic [31:0] fetch_count;

  int total;
  int bad;

  instruction_fetch #(
    .XLEN       (64),
    .RESET_PC   (64'd0),
    .IMEM_WORDS (32)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .id_valid       (id_valid),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_pc_plus4    (id_pc_plus4),
    .fault          (fault),
    .fault_pc       (fault_pc),
    .fetch_count    (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory model contents.
  function automatic logic [31:0] word_of(input logic [63:0] idx);
    if (idx == 64'd0) return 32'h0100_2083;
    if (idx == 64'd1) return 32'h0150_2103;
    return 32'hA000_0000 | 32'(idx);
  endfunction

  assign imem_data = (imem_addr < 64'd32) ? word_of(imem_addr) : 32'h0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        rv;
    logic [63:0] rpc;
    logic        rdy;
    logic        exp_valid;
    logic [63:0] exp_pc;
    logic [63:0] exp_addr;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rv, input logic [63:0] rpc, input logic rdy,
                              input logic ev, input logic [63:0] epc,
                              input logic [63:0] eaddr, input logic [31:0] ecnt);
    vec_t v;
    v.rv = rv; v.rpc = rpc; v.rdy = rdy;
    v.exp_valid = ev; v.exp_pc = epc; v.exp_addr = eaddr; v.exp_cnt = ecnt;
    return v;
  endfunction

  logic [63:0] last_pc;
  bit          got_fault;

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    id_ready       = 1'b1;

    // Boot, straight-line fetch, stall, redirect, redirect with consume.
    vecs.push_back(mk(0, 0,  1, 0, 0,  0, 0));   // BOOT cycle
    vecs.push_back(mk(0, 0,  1, 1, 0,  1, 1));
    vecs.push_back(mk(0, 0,  1, 1, 4,  2, 2));
    vecs.push_back(mk(0, 0,  1, 1, 8,  3, 3));
    vecs.push_back(mk(0, 0,  0, 1, 8,  3, 3));   // stall x3
    vecs.push_back(mk(0, 0,  0, 1, 8,  3, 3));
    vecs.push_back(mk(0, 0,  0, 1, 8,  3, 3));
    vecs.push_back(mk(0, 0,  1, 1, 12, 4, 4));   // resume
    vecs.push_back(mk(0, 0,  1, 1, 16, 5, 5));
    vecs.push_back(mk(0, 0,  1, 1, 20, 6, 6));
    vecs.push_back(mk(0, 0,  1, 1, 24, 7, 7));   // pc now 28
    vecs.push_back(mk(1, 8,  0, 0, 0,  2, 7));   // redirect, decode not ready
    vecs.push_back(mk(0, 0,  0, 1, 8,  3, 8));
    vecs.push_back(mk(0, 0,  1, 1, 12, 4, 9));
    vecs.push_back(mk(1, 0,  1, 0, 0,  0, 9));   // redirect while consumed
    vecs.push_back(mk(0, 0,  1, 1, 0,  1, 10));

    repeat (2) tick();
    chk("rst_valid", 64'(id_valid), 64'd0);
    chk("rst_instr", 64'(id_instr), 64'h13);
    chk("rst_id_pc", id_pc, 64'd0);
    chk("rst_pc4",   id_pc_plus4, 64'd0);
    chk("rst_fault", 64'(fault), 64'd0);
    chk("rst_fpc",   fault_pc, 64'd0);
    chk("rst_cnt",   64'(fetch_count), 64'd0);
    chk("rst_addr",  imem_addr, 64'd0);

    rst_n = 1'b1;
    #1;
    chk("boot0_valid", 64'(id_valid), 64'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      redirect_valid = vecs[i].rv;
      redirect_pc    = vecs[i].rpc;
      id_ready       = vecs[i].rdy;
      tick();
      chk($sformatf("v%0d_valid", i), 64'(id_valid), 64'(vecs[i].exp_valid));
      chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].exp_addr);
      chk($sformatf("v%0d_cnt", i), 64'(fetch_count), 64'(vecs[i].exp_cnt));
      chk($sformatf("v%0d_fault", i), 64'(fault), 64'd0);
      if (vecs[i].exp_valid) begin
        chk($sformatf("v%0d_id_pc", i), id_pc, vecs[i].exp_pc);
        chk($sformatf("v%0d_pc4", i), id_pc_plus4, vecs[i].exp_pc + 64'd4);
        chk($sformatf("v%0d_instr", i), 64'(id_instr), 64'(word_of(vecs[i].exp_pc >> 2)));
      end
    end

    // Misaligned redirect: pc is 4 at this point and must stay there.
    redirect_valid = 1'b1;
    redirect_pc    = 64'h6;
    id_ready       = 1'b1;
    tick();
    chk("mis_fault", 64'(fault), 64'd1);
    chk("mis_fpc",   fault_pc, 64'h6);
    chk("mis_valid", 64'(id_valid), 64'd0);
    chk("mis_addr",  imem_addr, 64'd1);
    chk("mis_cnt",   64'(fetch_count), 64'd10);
    redirect_pc = 64'h0;
    tick();
    chk("mis_ign_addr", imem_addr, 64'd1);
    chk("mis_ign_fpc",  fault_pc, 64'h6);
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("mis_hold%0d_valid", i), 64'(id_valid), 64'd0);
      chk($sformatf("mis_hold%0d_fault", i), 64'(fault), 64'd1);
      chk($sformatf("mis_hold%0d_cnt", i), 64'(fetch_count), 64'd10);
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("mis_rst_fault", 64'(fault), 64'd0);
    chk("mis_rst_fpc",   fault_pc, 64'd0);
    chk("mis_rst_addr",  imem_addr, 64'd0);

    // Out-of-range: straight-line run until the fetch leaves the memory.
    #1;
    rst_n = 1'b1;
    last_pc   = '1;
    got_fault = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (fault) begin
        got_fault = 1'b1;
        break;
      end
      if (id_valid) last_pc = id_pc;
    end
    chk("oor_reached", 64'(got_fault), 64'd1);
    chk("oor_last_pc", last_pc, 64'd124);
    chk("oor_fpc",     fault_pc, 64'd128);
    chk("oor_cnt",     64'(fetch_count), 64'd32);
    chk("oor_valid",   64'(id_valid), 64'd0);
    chk("oor_addr",    imem_addr, 64'd32);
    tick();
    chk("oor_hold_addr",  imem_addr, 64'd32);
    chk("oor_hold_valid", 64'(id_valid), 64'd0);

    // Reset mid-stream with a valid entry in IF/ID.
    #2;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    repeat (4) tick();
    chk("mid_pre_valid", 64'(id_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_valid", 64'(id_valid), 64'd0);
    chk("mid_instr", 64'(id_instr), 64'h13);
    chk("mid_addr",  imem_addr, 64'd0);
    chk("mid_id_pc", id_pc, 64'd0);
    chk("mid_cnt",   64'(fetch_count), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
